// File: rtl/fft4_pkg.sv
// Shared types for the 4-point FFT front end: complex lane, frame and
// bank/slot index types.
package fft4_pkg;

    localparam int DW  = 8;
    localparam int NPT = 4;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef cplx_t [NPT-1:0] frame_t;

    typedef logic       bank_t;
    typedef logic [1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NPT - 1);

endpackage

// File: rtl/fft4_frame_bank.sv
// One frame buffer bank: four complex slot registers plus a full flag.
// Writing slot 0 starts a new frame, so the other slots are zeroed.
module fft4_frame_bank
    import fft4_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_en,
    input  slot_t  wr_slot,
    input  cplx_t  wr_data,
    input  logic   set_full,
    input  logic   clr_full,
    output frame_t slots,
    output logic   full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
            full  <= 1'b0;
        end else begin
            if (wr_en) begin
                // Later assignment wins, so slot 0 keeps the sample.
                if (wr_slot == '0) begin
                    for (int k = 1; k < NPT; k++) begin
                        slots[k] <= '0;
                    end
                end
                slots[wr_slot] <= wr_data;
            end
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft4_frame_loader.sv
// Packs a complex sample stream into 4-slot frames for the FFT core using a
// ping-pong pair of banks, sustaining one sample per clock.
module fft4_frame_loader
    import fft4_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_real,
    input  logic signed [DW-1:0] s_imag,
    input  logic                 s_last,
    output logic                 f_valid,
    input  logic                 f_ready,
    output logic signed [DW-1:0] f_real_0,
    output logic signed [DW-1:0] f_real_1,
    output logic signed [DW-1:0] f_real_2,
    output logic signed [DW-1:0] f_real_3,
    output logic signed [DW-1:0] f_imag_0,
    output logic signed [DW-1:0] f_imag_1,
    output logic signed [DW-1:0] f_imag_2,
    output logic signed [DW-1:0] f_imag_3,
    output logic                 err_short
);

    bank_t  wr_bank;
    bank_t  rd_bank;
    slot_t  wr_idx;
    logic   [1:0] full;
    frame_t bank_slots [2];
    frame_t rd_frame;
    cplx_t  sample;
    logic   accept;
    logic   close;
    logic   consume;

    // Both handshake readies come straight from registered full flags, so
    // there is no combinational f_ready -> s_ready path.
    assign s_ready = !full[wr_bank];
    assign f_valid = full[rd_bank];
    assign accept  = s_valid && s_ready;
    assign close   = accept && ((wr_idx == LAST_SLOT) || s_last);
    assign consume = f_valid && f_ready;
    assign sample  = '{re: s_real, im: s_imag};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft4_frame_bank u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (accept && (wr_bank == bank_t'(b))),
            .wr_slot  (wr_idx),
            .wr_data  (sample),
            .set_full (close && (wr_bank == bank_t'(b))),
            .clr_full (consume && (rd_bank == bank_t'(b))),
            .slots    (bank_slots[b]),
            .full     (full[b])
        );
    end

    assign rd_frame = rd_bank ? bank_slots[1] : bank_slots[0];
    assign f_real_0 = rd_frame[0].re;
    assign f_real_1 = rd_frame[1].re;
    assign f_real_2 = rd_frame[2].re;
    assign f_real_3 = rd_frame[3].re;
    assign f_imag_0 = rd_frame[0].im;
    assign f_imag_1 = rd_frame[1].im;
    assign f_imag_2 = rd_frame[2].im;
    assign f_imag_3 = rd_frame[3].im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            err_short <= 1'b0;
        end else begin
            // A close before the last slot can only have come from s_last.
            err_short <= close && (wr_idx != LAST_SLOT);
            if (accept) begin
                if (close) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 2'd1;
                end
            end
            if (consume) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft4_frame_loader.sv
// Scoreboard bench: a frame-FIFO model predicts frames, readiness and
// short-frame pulses; a negedge monitor compares them with the loader.
module tb_fft4_frame_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_ready, s_last;
    logic [7:0] s_real, s_imag;
    logic       f_valid, f_ready, err_short;
    logic [7:0] f_real_0, f_real_1, f_real_2, f_real_3;
    logic [7:0] f_imag_0, f_imag_1, f_imag_2, f_imag_3;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0][7:0] re;
        logic [3:0][7:0] im;
    } xframe_t;

    xframe_t    exp_q [$];
    logic [7:0] cur_re [$];
    logic [7:0] cur_im [$];
    int         stored  = 0;
    logic       err_exp = 1'b0;

    always #5 clk = ~clk;

    fft4_frame_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_real    (s_real),
        .s_imag    (s_imag),
        .s_last    (s_last),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_real_0  (f_real_0),
        .f_real_1  (f_real_1),
        .f_real_2  (f_real_2),
        .f_real_3  (f_real_3),
        .f_imag_0  (f_imag_0),
        .f_imag_1  (f_imag_1),
        .f_imag_2  (f_imag_2),
        .f_imag_3  (f_imag_3),
        .err_short (err_short)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the loader behaves as a two-deep FIFO of frames; samples are
    // gathered into groups of four (or fewer when s_last) padded with zeros.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            cur_re.delete();
            cur_im.delete();
            stored  = 0;
            err_exp = 1'b0;
        end else begin
            logic    acc, cons, err_next;
            xframe_t fr;
            acc      = s_valid && (stored < 2);
            cons     = (stored > 0) && f_ready;
            err_next = 1'b0;
            if (cons) stored--;
            if (acc) begin
                cur_re.push_back(s_real);
                cur_im.push_back(s_imag);
                if (cur_re.size() == 4 || s_last) begin
                    err_next = (cur_re.size() < 4);
                    fr = '0;
                    for (int k = 0; k < cur_re.size(); k++) begin
                        fr.re[k] = cur_re[k];
                        fr.im[k] = cur_im[k];
                    end
                    exp_q.push_back(fr);
                    cur_re.delete();
                    cur_im.delete();
                    stored++;
                end
            end
            err_exp = err_next;
        end
    end

    always @(negedge clk) begin
        xframe_t e;
        chk("f_valid", f_valid, stored > 0);
        chk("s_ready", s_ready, stored < 2);
        chk("err_short", err_short, err_exp);
        if (f_valid) begin
            if (exp_q.size() == 0) begin
                chk("frame_expected", exp_q.size(), 1);
            end else begin
                e = exp_q[0];
                chk("f_real_0", f_real_0, e.re[0]);
                chk("f_real_1", f_real_1, e.re[1]);
                chk("f_real_2", f_real_2, e.re[2]);
                chk("f_real_3", f_real_3, e.re[3]);
                chk("f_imag_0", f_imag_0, e.im[0]);
                chk("f_imag_1", f_imag_1, e.im[1]);
                chk("f_imag_2", f_imag_2, e.im[2]);
                chk("f_imag_3", f_imag_3, e.im[3]);
                if (f_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] re, input logic [7:0] im, input logic last);
        int   n;
        logic acc;
        n       = 0;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_real  = re;
        s_imag  = im;
        s_last  = last;
        do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_real  = '0;
        s_imag  = '0;
        f_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_f_valid", f_valid, 0);
        chk("reset_s_ready", s_ready, 1);
        chk("reset_f_real_0", f_real_0, 0);

        for (int n = 1; n <= 4; n++) send(8'(n), 8'd0, 1'b0);
        idle(3);

        for (int n = 0; n < 12; n++) send(8'(n), 8'(-n), 1'b0);
        idle(3);

        f_ready = 1'b0;
        fork
            begin
                for (int n = 0; n < 10; n++) send(8'(n), 8'(n + 100), 1'b0);
            end
            begin
                repeat (25) @(posedge clk);
                #1 f_ready = 1'b1;
            end
        join
        send(8'd10, 8'd110, 1'b0);
        send(8'd11, 8'd111, 1'b0);
        idle(3);

        send(8'd5, 8'd1, 1'b0);
        send(8'd6, 8'd2, 1'b1);
        for (int n = 0; n < 4; n++) send(8'(20 + n), 8'(n), 1'b0);
        idle(3);

        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_f_valid", f_valid, 0);
        chk("async_rst_s_ready", s_ready, 1);
        chk("async_rst_err", err_short, 0);
        chk("async_rst_f_real_0", f_real_0, 0);
        chk("async_rst_f_imag_1", f_imag_1, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 7; n <= 10; n++) send(8'(n), 8'(n), 1'b0);
        idle(3);

        f_ready = 1'b0;
        for (int n = 0; n < 4; n++) send(8'($urandom), 8'($urandom), 1'b0);
        for (int c = 0; c < 30; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_real  = 8'($urandom);
            s_imag  = 8'($urandom);
            s_last  = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        f_ready = 1'b1;
        idle(10);

        for (int c = 0; c < 400; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_real  = 8'($urandom);
            s_imag  = 8'($urandom);
            s_last  = ($urandom_range(0, 7) == 0);
            f_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        f_ready = 1'b1;
        idle(10);
        chk("frames_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fft4_frame_loader.md
Name: fft4_frame_loader

Overview:
- Upstream stage of the combinational 4-point FFT core.
- Accepts a stream of complex samples (8-bit real and 8-bit imag), one per handshake.
- Packs every 4 consecutive samples into a natural-order frame (slot 0..3) and presents all 8 lanes in parallel to the core's real_in_0..3 / imag_in_0..3.
- Double-buffered, so it sustains 1 sample/clk while a completed frame waits for downstream.

Parameters:
DW, 8, bit width of each real/imag lane; must match the FFT core (8).
NPT, 4, points per frame; fixed at 4, not user-overridable in this revision.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset: one clock; reset is asynchronous and active-low
s_valid  in  1  input sample valid
s_ready  out  1  loader can accept a sample this cycle
s_real  in  DW  sample real part, two's complement
s_imag  in  DW  sample imag part, two's complement
s_last  in  1  sample is the last of a (possibly short) frame
f_valid  out  1  complete frame presented on f_real_*/f_imag_*
f_ready  in  1  downstream consumes frame
f_real_0..f_real_3  out  DW each  frame real slots 0..3, to FFT real_in_0..3
f_imag_0..f_imag_3  out  DW each  frame imag slots 0..3, to FFT imag_in_0..3
err_short  out  1  one-cycle pulse: frame closed early by s_last

Behaviour:
- Storage: two banks (A=0, B=1), each holding 4 real + 4 imag registers plus a full flag.
- Write side: wr_bank pointer and wr_idx counter (0..3). s_ready = !full[wr_bank].
- Accept means s_valid && s_ready. On accept, the sample is written to slot wr_idx of wr_bank.
- Slot handling:
  - A write to slot 0 also clears slots 1..3 of that bank to 0.
  - Unwritten slots therefore read 0.
- Frame close: occurs on accept with wr_idx==3, or on accept with s_last=1. On close:
  - full[wr_bank] is set.
  - wr_bank toggles.
  - wr_idx returns to 0.
- Otherwise each accept increments wr_idx.
- err_short: pulses high for exactly the cycle after a close caused by s_last with wr_idx<3. s_last at wr_idx==3 is a normal close with no error.
- Read side: rd_bank pointer. f_valid = full[rd_bank]. f_real_k/f_imag_k = slot k of rd_bank, registered, and held stable while f_valid && !f_ready.
- Frame consume: on f_valid && f_ready, full[rd_bank] is cleared and rd_bank toggles.
- Latency: f_valid rises on the clock edge that accepts the closing sample (visible the next cycle).
- Throughput: with f_ready tied high, s_ready never drops, giving 1 sample/clk indefinitely.
- Simultaneous events:
  - A close on one bank and a consume on the other in the same cycle are both honoured.
  - A consume of the bank currently being waited on frees it the same edge; s_ready rises the following cycle, with no combinational f_ready->s_ready path.
- Backpressure: with both banks full, s_ready=0. Input data is ignored and wr_idx is held.
- s_valid with s_ready=0 has no effect.
- Reset (async assert, any time including mid-frame):
  - full[*]=0, wr_bank=rd_bank=0, wr_idx=0.
  - All slot registers = 0, err_short=0, f_valid=0, s_ready=1 once reset is released.
  - A partial frame is discarded.
- Reset release is synchronous to clk: the first accept can occur on the first edge after deassertion.
- Arithmetic: none on data; data passes bit-exact. No sign extension or scaling.

Decomposition:
- Package fft4_pkg:
  - DW, NPT constants.
  - typedef cplx_t {real[DW-1:0], imag[DW-1:0]}.
  - typedef frame_t (array of NPT cplx_t).
  - Bank index type (1 bit).
  - Slot index type (2 bits).
- One sub-module is natural: fft4_frame_bank. It holds one bank's slot registers, full flag, clear-on-slot-0 logic, and set/clear of full. It is instantiated twice, with the top level owning the pointers, wr_idx, the output mux and err_short.

Test Plan:
- Stream samples (1+0j),(2+0j),(3+0j),(4+0j) with f_ready=1:
  - f_valid high 1 cycle after the 4th accept.
  - f_real_0..3=1,2,3,4; f_imag_*=0; s_ready stays 1.
- Continuous stream of 12 samples (real=n, imag=-n) with f_ready=1:
  - three frames in order: {0..3}, {4..7}, {8..11}, each with imag = the two's complement of real.
  - no s_ready gaps.
- f_ready=0 while streaming 10 samples:
  - two frames fill; s_ready drops after the 8th accept.
  - samples 9 and 10 are held off.
  - raising f_ready releases frame {0..3} then frame {4..7}.
  - samples 9 and 10 are then accepted into the freed bank.
- s_last on the 2nd sample (values 5+1j, 6+2j):
  - frame is (5+1j),(6+2j),0,0.
  - err_short pulses once.
  - next 4 samples form a normal frame with no error.
- Assert rst_n=0 asynchronously (mid-clock) after 2 samples of a frame:
  - outputs go to reset values immediately.
  - after release, the next 4 samples (7,8,9,10) form frame 7,8,9,10; no stale data appears.
- Hold f_valid with f_ready=0 and toggle s_valid randomly:
  - f_real_*/f_imag_* remain bit-stable until consumed.
